// File: rtl/dds_pkg.sv
// Shared constants and the elaboration-time sine table generator for the
// multi-channel DDS.
package dds_pkg;

  localparam logic [1:0] CFG_FREQ  = 2'd0;
  localparam logic [1:0] CFG_PHASE = 2'd1;
  localparam logic [1:0] CFG_STEP  = 2'd2;
  localparam logic [1:0] CFG_LIMIT = 2'd3;

  // Offset-binary full-cycle sine entry k of a 2^lut_aw table, rounded half away from zero.
  function automatic int sine_lut(input int lut_aw, input int out_w, input int k);
    real amp, x;
    amp = real'((1 << (out_w - 1)) - 1);
    x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << lut_aw));
    if (x >= 0.0) return (1 << (out_w - 1)) + $rtoi(x + 0.5);
    else          return (1 << (out_w - 1)) - $rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/dds_multi_gen_if.sv
// Strobe, config and sample bus between the register block / DAC path and the
// DDS generator.
interface dds_multi_gen_if #(
  parameter int NCH    = 2,
  parameter int ACC_W  = 16,
  parameter int LUT_AW = 7,
  parameter int OUT_W  = 12,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) ();
  logic                    en;
  logic                    sync_in;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [1:0]              cfg_sel;
  logic [ACC_W-1:0]        cfg_data;
  logic [NCH*OUT_W-1:0]    out_data;
  logic                    out_valid;
  logic [NCH*LUT_AW-1:0]   phase_mon;

  modport master (
    output en, sync_in, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  out_data, out_valid, phase_mon
  );
  modport slave (
    input  en, sync_in, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output out_data, out_valid, phase_mon
  );
endinterface

// File: rtl/dds_interp.sv
// One channel's table read (S2) and linear interpolation (S3); the valid
// pipeline lives in the parent and drives the stage loads.
module dds_interp
  import dds_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int LUT_AW = 7,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld2,
  input  logic              ld3,
  input  logic [ACC_W-1:0]  p,
  output logic [OUT_W-1:0]  out,
  output logic [LUT_AW-1:0] idx
);
  localparam int FRAC_W = ACC_W - LUT_AW;
  localparam int NENT   = 1 << LUT_AW;
  localparam int PW     = OUT_W + FRAC_W + 2;

  logic [OUT_W-1:0] lut [NENT];
  for (genvar k = 0; k < NENT; k++) begin : g_lut
    localparam logic [OUT_W-1:0] VAL = OUT_W'(sine_lut(LUT_AW, OUT_W, k));
    assign lut[k] = VAL;
  end

  logic [LUT_AW-1:0] i_s1, i_nxt, i_s2;
  logic [OUT_W-1:0]  a_s2, b_s2, out_nxt;
  logic [FRAC_W-1:0] f_s2;
  logic signed [OUT_W:0]  diff;
  logic signed [PW-1:0]   prod;

  assign i_s1  = p[ACC_W-1:FRAC_W];
  assign i_nxt = i_s1 + LUT_AW'(1);   // natural wrap from top entry back to 0

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_s2 <= '0;
      a_s2 <= '0;
      b_s2 <= '0;
      f_s2 <= '0;
    end else if (ld2) begin
      i_s2 <= i_s1;
      a_s2 <= lut[i_s1];
      b_s2 <= lut[i_nxt];
      f_s2 <= p[FRAC_W-1:0];
    end
  end

  // Signed slope times fraction, arithmetic shift floors toward -inf.
  assign diff    = $signed({1'b0, b_s2}) - $signed({1'b0, a_s2});
  assign prod    = PW'(diff) * PW'($signed({1'b0, f_s2}));
  assign out_nxt = a_s2 + OUT_W'(prod >>> FRAC_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= {1'b1, {(OUT_W-1){1'b0}}};
      idx <= '0;
    end else if (ld3) begin
      out <= out_nxt;
      idx <= i_s2;
    end
  end
endmodule

// File: rtl/dds_multi_gen.sv
// Multi-channel DDS: per-channel phase accumulators with optional linear
// frequency sweep, feeding one interpolating sine stage per channel.
module dds_multi_gen
  import dds_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ACC_W  = 16,
  parameter int LUT_AW = 7,
  parameter int OUT_W  = 12,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic             clk,
  input logic             rst,
  dds_multi_gen_if.slave  bus
);
  localparam int STAGES = 3;

  logic [NCH-1:0][ACC_W-1:0]  acc, freq, cur_inc, phase, step, limit, p_s1, sw_inc;
  logic [NCH-1:0][OUT_W-1:0]  out_arr;
  logic [NCH-1:0][LUT_AW-1:0] idx_arr;
  logic [STAGES:1]            vld_pipe;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [ACC_W:0] nxt;
    assign nxt = {1'b0, cur_inc[c]} + {1'b0, step[c]};
    // Sweep falls back to the base frequency once it would pass the limit.
    assign sw_inc[c] = (step[c] == '0)            ? cur_inc[c] :
                       (nxt > {1'b0, limit[c]})   ? freq[c]    : nxt[ACC_W-1:0];

    dds_interp #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_interp (
      .clk (clk),
      .rst (rst),
      .ld2 (vld_pipe[1]),
      .ld3 (vld_pipe[2]),
      .p   (p_s1[c]),
      .out (out_arr[c]),
      .idx (idx_arr[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      freq     <= '0;
      cur_inc  <= '0;
      phase    <= '0;
      step     <= '0;
      limit    <= '1;
      p_s1     <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.en};
      for (int c = 0; c < NCH; c++) begin
        if (bus.en) begin
          p_s1[c]    <= acc[c] + phase[c];
          acc[c]     <= acc[c] + cur_inc[c];
          cur_inc[c] <= sw_inc[c];
        end
        if (bus.sync_in) begin
          acc[c]     <= '0;
          cur_inc[c] <= freq[c];
        end
        // Late assignment lets a FREQ write win over sweep/sync reloads.
        if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
          case (bus.cfg_sel)
            CFG_FREQ: begin
              freq[c]    <= bus.cfg_data;
              cur_inc[c] <= bus.cfg_data;
            end
            CFG_PHASE: phase[c] <= bus.cfg_data;
            CFG_STEP:  step[c]  <= bus.cfg_data;
            default:   limit[c] <= bus.cfg_data;
          endcase
        end
      end
    end
  end

  assign bus.out_data  = out_arr;
  assign bus.phase_mon = idx_arr;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_dds_multi_gen.sv
// Directed + randomized bench for dds_multi_gen against a cycle-level model
// built from plain arithmetic and a queue of pending samples.
module tb_dds_multi_gen;
  import dds_pkg::*;

  localparam int NCH    = 2;
  localparam int ACC_W  = 16;
  localparam int LUT_AW = 7;
  localparam int OUT_W  = 12;
  localparam int CH_W   = 1;
  localparam int FRAC_W = ACC_W - LUT_AW;
  localparam int NENT   = 1 << LUT_AW;
  localparam longint MASK = (64'd1 << ACC_W) - 1;
  localparam int MID    = 1 << (OUT_W - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_multi_gen_if #(.NCH(NCH), .ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W), .CH_W(CH_W)) bus ();
  dds_multi_gen #(.NCH(NCH), .ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int ref_lut [NENT];
  longint m_acc[NCH], m_freq[NCH], m_inc[NCH], m_ph[NCH], m_step[NCH], m_lim[NCH];

  typedef struct {
    int                     due;
    logic [NCH*OUT_W-1:0]   data;
    logic [NCH*LUT_AW-1:0]  idx;
  } samp_t;
  samp_t pend[$];
  int cyc = 0;
  logic                   exp_valid;
  logic [NCH*OUT_W-1:0]   exp_data;
  logic [NCH*LUT_AW-1:0]  exp_idx;

  function automatic int ref_sample(longint p);
    int i, f, a, b;
    i = int'(p >> FRAC_W);
    f = int'(p) & ((1 << FRAC_W) - 1);
    a = ref_lut[i];
    b = ref_lut[(i + 1) % NENT];
    return a + int'($floor(real'((b - a) * f) / real'(1 << FRAC_W)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the rules for one posedge using the inputs currently driven.
  task automatic model_edge();
    samp_t s;
    longint n, new_acc, new_inc;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_freq[c] = 0; m_inc[c] = 0;
        m_ph[c] = 0; m_step[c] = 0; m_lim[c] = MASK;
      end
      pend.delete();
      for (int c = 0; c < NCH; c++) exp_data[c*OUT_W +: OUT_W] = OUT_W'(MID);
      exp_idx = '0;
      return;
    end
    if (bus.en) begin
      s.due = cyc + 3;
      for (int c = 0; c < NCH; c++) begin
        n = (m_acc[c] + m_ph[c]) & MASK;
        s.data[c*OUT_W +: OUT_W]  = OUT_W'(ref_sample(n));
        s.idx[c*LUT_AW +: LUT_AW] = LUT_AW'(n >> FRAC_W);
      end
      pend.push_back(s);
    end
    for (int c = 0; c < NCH; c++) begin
      new_acc = m_acc[c];
      new_inc = m_inc[c];
      if (bus.en) begin
        new_acc = (m_acc[c] + m_inc[c]) & MASK;
        if (m_step[c] != 0) begin
          n = m_inc[c] + m_step[c];
          new_inc = (n > m_lim[c]) ? m_freq[c] : n;
        end
      end
      if (bus.sync_in) begin
        new_acc = 0;
        new_inc = m_freq[c];
      end
      if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
        case (bus.cfg_sel)
          2'd0: begin m_freq[c] = bus.cfg_data; new_inc = bus.cfg_data; end
          2'd1: m_ph[c]   = bus.cfg_data;
          2'd2: m_step[c] = bus.cfg_data;
          default: m_lim[c] = bus.cfg_data;
        endcase
      end
      m_acc[c] = new_acc;
      m_inc[c] = new_inc;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      if (pend[0].due == cyc) exp_valid = 1'b1;
      exp_data = pend[0].data;
      exp_idx  = pend[0].idx;
      void'(pend.pop_front());
    end
    chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    chk("out_data",  64'(bus.out_data),  64'(exp_data));
    chk("phase_mon", 64'(bus.phase_mon), 64'(exp_idx));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg(input int ch, input logic [1:0] sel, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_sel  = sel;
    bus.cfg_data = ACC_W'(data);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    real x;
    for (int k = 0; k < NENT; k++) begin
      x = real'(MID - 1) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(NENT));
      ref_lut[k] = (x >= 0.0) ? MID + $rtoi(x + 0.5) : MID - $rtoi(0.5 - x);
    end

    rst = 1'b0;
    bus.en = 1'b1; bus.sync_in = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
    ticks(2);
    chk("reset_out_data", 64'(bus.out_data), 64'(24'h800800));
    chk("reset_phase_mon", 64'(bus.phase_mon), 64'(0));

    // Release, configure ch0 with en low, then a long continuous run.
    rst = 1'b1; bus.en = 1'b0;
    ticks(2);
    cfg(0, CFG_FREQ, 655);
    bus.en = 1'b1;
    ticks(200);

    // Ch1 parked at a quarter cycle.
    cfg(1, CFG_FREQ, 0);
    cfg(1, CFG_PHASE, 16'h4000);
    ticks(4);
    chk("ch1_quarter", 64'(bus.out_data[2*OUT_W-1:OUT_W]), 64'(12'hFFF));

    // Ch0 frozen at a known fraction, then across the table wrap.
    cfg(0, CFG_FREQ, 0);
    bus.sync_in = 1'b1; tick(); bus.sync_in = 1'b0;
    cfg(0, CFG_PHASE, 16'h0100);
    ticks(4);
    chk("ch0_frac_half", 64'(bus.out_data[OUT_W-1:0]), 64'(12'h832));
    cfg(0, CFG_PHASE, 16'hFF00);
    ticks(4);
    chk("ch0_wrap", 64'(bus.out_data[OUT_W-1:0]), 64'(12'd1998));
    chk("ch0_wrap_idx", 64'(bus.phase_mon[LUT_AW-1:0]), 64'(127));

    // Chirp with sweep limit.
    cfg(0, CFG_PHASE, 0);
    cfg(0, CFG_STEP, 50);
    cfg(0, CFG_LIMIT, 300);
    cfg(0, CFG_FREQ, 100);
    bus.sync_in = 1'b1; tick(); bus.sync_in = 1'b0;
    ticks(20);
    cfg(0, CFG_STEP, 0);

    // Sync mid-run, frequency change under en, then en gap.
    cfg(1, CFG_FREQ, 3000);
    ticks(7);
    bus.sync_in = 1'b1; tick(); bus.sync_in = 1'b0;
    ticks(3);
    cfg(0, CFG_FREQ, 1234);
    ticks(5);
    bus.en = 1'b0;
    ticks(5);
    bus.en = 1'b1;
    ticks(5);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      bus.en       = ($urandom_range(3) != 0);
      bus.sync_in  = ($urandom_range(40) == 0);
      bus.cfg_we   = ($urandom_range(4) == 0);
      bus.cfg_ch   = CH_W'($urandom_range(NCH - 1));
      bus.cfg_sel  = 2'($urandom_range(3));
      bus.cfg_data = ACC_W'($urandom);
      tick();
    end
    bus.cfg_we = 1'b0; bus.sync_in = 1'b0;

    // Reset with samples in flight, then restart.
    bus.en = 1'b1;
    ticks(3);
    rst = 1'b0; tick();
    rst = 1'b1;
    bus.en = 1'b0; ticks(2);
    cfg(0, CFG_FREQ, 777);
    bus.en = 1'b1;
    ticks(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
